// File: rtl/mmu_arb_pkg.sv
// Shared constants for the MMU access arbiter: owner IDs, the fixed fetch
// request shape, and the encoding of MMU completion types.
package mmu_arb_pkg;

  localparam logic PL_OWNER_IF = 1'b0;
  localparam logic PL_OWNER_LS = 1'b1;

  localparam logic [1:0] PL_IF_ORDER = 2'h2;
  localparam logic [3:0] PL_IF_MASK  = 4'hf;

  typedef enum logic [1:0] {
    CPL_NONE  = 2'd0,
    CPL_DATA  = 2'd1,
    CPL_FAULT = 2'd2
  } cpl_type_t;

  // The MMU never raises both; a fault is given precedence defensively.
  function automatic cpl_type_t cplDecode(input logic valid, input logic fault);
    if (fault)      return CPL_FAULT;
    else if (valid) return CPL_DATA;
    else            return CPL_NONE;
  endfunction

endpackage

// File: rtl/mmu_arb_id_fifo.sv
// In-order owner-ID FIFO (width 1, depth P_DEPTH) tracking requests that
// the MMU still owes a completion for.
module mmu_arb_id_fifo #(
  parameter int P_DEPTH = 4
) (
  input  logic                       iCLOCK,
  input  logic                       iRESET_SYNC,
  input  logic                       iPUSH,
  input  logic                       iPUSH_DATA,
  input  logic                       iPOP,
  output logic                       oHEAD,
  output logic [$clog2(P_DEPTH):0]   oCOUNT,
  output logic                       oEMPTY
);
  localparam int PW = $clog2(P_DEPTH);
  localparam logic [PW:0] CNT_FULL = P_DEPTH[PW:0];

  logic          mem [P_DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [PW:0]   count;
  logic          doPush;
  logic          doPop;

  assign doPush = iPUSH && (count != CNT_FULL);
  assign doPop  = iPOP && (count != '0);

  always_ff @(posedge iCLOCK) begin
    if (doPush) mem[wrPtr] <= iPUSH_DATA;
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign oHEAD  = mem[rdPtr];
  assign oCOUNT = count;
  assign oEMPTY = (count == '0);

endmodule

// File: rtl/mmu_access_arbiter.sv
// Shares the MMU logic-request port between fetch (IF) and load/store (LS)
// and routes completions back in order. Define MMU_ARB_ROUND_ROBIN_EN for
// round-robin arbitration; otherwise LS has fixed priority over IF.
module mmu_access_arbiter
  import mmu_arb_pkg::*;
#(
  parameter int P_DEPTH = 4
) (
  input  logic        iCLOCK,
  input  logic        iRESET_SYNC,
  input  logic        iIF_REQ,
  output logic        oIF_LOCK,
  input  logic [31:0] iIF_ADDR,
  input  logic        iLS_REQ,
  output logic        oLS_LOCK,
  input  logic [1:0]  iLS_ORDER,
  input  logic [3:0]  iLS_MASK,
  input  logic        iLS_RW,
  input  logic [31:0] iLS_ADDR,
  input  logic [31:0] iLS_DATA,
  output logic        oMMU_REQ,
  input  logic        iMMU_LOCK,
  output logic [1:0]  oMMU_ORDER,
  output logic [3:0]  oMMU_MASK,
  output logic        oMMU_RW,
  output logic [31:0] oMMU_ADDR,
  output logic [31:0] oMMU_DATA,
  input  logic        iMMU_VALID,
  input  logic [63:0] iMMU_DATA,
  input  logic        iMMU_PAGEFAULT,
  output logic        oIF_VALID,
  output logic        oLS_VALID,
  output logic [63:0] oRESP_DATA,
  output logic        oRESP_PAGEFAULT
);
  localparam int CW = $clog2(P_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_FULL = P_DEPTH[CW-1:0];

  logic [CW-1:0] fifoCount;
  logic          fifoHead;
  logic          fifoEmpty;
  logic          outFree;
  logic          canGrant;
  logic          ifWinsTie;
  logic          grantIf;
  logic          grantLs;
  logic          grant;
  logic          grantOwner;
  cpl_type_t     cplType;
  logic          cplPop;

  // The count is taken before any same-cycle pop, so a full FIFO always blocks.
  assign outFree  = !oMMU_REQ || !iMMU_LOCK;
  assign canGrant = !iRESET_SYNC && outFree && (fifoCount < CNT_FULL);

`ifdef MMU_ARB_ROUND_ROBIN_EN
  logic rrNextIf;

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC)  rrNextIf <= 1'b1;
    else if (grant)   rrNextIf <= grantLs;
  end

  assign ifWinsTie = rrNextIf;
`else
  assign ifWinsTie = 1'b0;
`endif

  assign grantIf    = canGrant && iIF_REQ && (!iLS_REQ || ifWinsTie);
  assign grantLs    = canGrant && iLS_REQ && !grantIf;
  assign grant      = grantIf || grantLs;
  assign grantOwner = grantLs ? PL_OWNER_LS : PL_OWNER_IF;

  assign oIF_LOCK = !canGrant || grantLs;
  assign oLS_LOCK = !canGrant || grantIf;

  // Completions with nothing outstanding are protocol errors and are dropped.
  assign cplType = cplDecode(iMMU_VALID, iMMU_PAGEFAULT);
  assign cplPop  = (cplType != CPL_NONE) && !fifoEmpty;

  mmu_arb_id_fifo #(.P_DEPTH(P_DEPTH)) u_id_fifo (
    .iCLOCK      (iCLOCK),
    .iRESET_SYNC (iRESET_SYNC),
    .iPUSH       (grant),
    .iPUSH_DATA  (grantOwner),
    .iPOP        (cplPop),
    .oHEAD       (fifoHead),
    .oCOUNT      (fifoCount),
    .oEMPTY      (fifoEmpty)
  );

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      oMMU_REQ        <= 1'b0;
      oMMU_ORDER      <= '0;
      oMMU_MASK       <= '0;
      oMMU_RW         <= 1'b0;
      oMMU_ADDR       <= '0;
      oMMU_DATA       <= '0;
      oIF_VALID       <= 1'b0;
      oLS_VALID       <= 1'b0;
      oRESP_DATA      <= '0;
      oRESP_PAGEFAULT <= 1'b0;
    end else begin
      if (grantLs) begin
        oMMU_REQ   <= 1'b1;
        oMMU_ORDER <= iLS_ORDER;
        oMMU_MASK  <= iLS_MASK;
        oMMU_RW    <= iLS_RW;
        oMMU_ADDR  <= iLS_ADDR;
        oMMU_DATA  <= iLS_DATA;
      end else if (grantIf) begin
        oMMU_REQ   <= 1'b1;
        oMMU_ORDER <= PL_IF_ORDER;
        oMMU_MASK  <= PL_IF_MASK;
        oMMU_RW    <= 1'b0;
        oMMU_ADDR  <= iIF_ADDR;
        oMMU_DATA  <= '0;
      end else if (outFree) begin
        oMMU_REQ <= 1'b0;
      end
      oIF_VALID       <= cplPop && (fifoHead == PL_OWNER_IF);
      oLS_VALID       <= cplPop && (fifoHead == PL_OWNER_LS);
      oRESP_PAGEFAULT <= cplPop && (cplType == CPL_FAULT);
      if (cplPop) oRESP_DATA <= iMMU_DATA;
    end
  end

endmodule

// File: tb/tb_mmu_access_arbiter.sv
// Directed self-checking bench for mmu_access_arbiter (P_DEPTH=4); follows
// MMU_ARB_ROUND_ROBIN_EN for the arbitration expectations.
module tb_mmu_access_arbiter;

  logic        iCLOCK;
  logic        iRESET_SYNC;
  logic        iIF_REQ;
  logic        oIF_LOCK;
  logic [31:0] iIF_ADDR;
  logic        iLS_REQ;
  logic        oLS_LOCK;
  logic [1:0]  iLS_ORDER;
  logic [3:0]  iLS_MASK;
  logic        iLS_RW;
  logic [31:0] iLS_ADDR;
  logic [31:0] iLS_DATA;
  logic        oMMU_REQ;
  logic        iMMU_LOCK;
  logic [1:0]  oMMU_ORDER;
  logic [3:0]  oMMU_MASK;
  logic        oMMU_RW;
  logic [31:0] oMMU_ADDR;
  logic [31:0] oMMU_DATA;
  logic        iMMU_VALID;
  logic [63:0] iMMU_DATA;
  logic        iMMU_PAGEFAULT;
  logic        oIF_VALID;
  logic        oLS_VALID;
  logic [63:0] oRESP_DATA;
  logic        oRESP_PAGEFAULT;

  int n_checks;
  int n_fail;
  logic [0:0] exp_q[$];

  mmu_access_arbiter #(.P_DEPTH(4)) dut (
    .iCLOCK          (iCLOCK),
    .iRESET_SYNC     (iRESET_SYNC),
    .iIF_REQ         (iIF_REQ),
    .oIF_LOCK        (oIF_LOCK),
    .iIF_ADDR        (iIF_ADDR),
    .iLS_REQ         (iLS_REQ),
    .oLS_LOCK        (oLS_LOCK),
    .iLS_ORDER       (iLS_ORDER),
    .iLS_MASK        (iLS_MASK),
    .iLS_RW          (iLS_RW),
    .iLS_ADDR        (iLS_ADDR),
    .iLS_DATA        (iLS_DATA),
    .oMMU_REQ        (oMMU_REQ),
    .iMMU_LOCK       (iMMU_LOCK),
    .oMMU_ORDER      (oMMU_ORDER),
    .oMMU_MASK       (oMMU_MASK),
    .oMMU_RW         (oMMU_RW),
    .oMMU_ADDR       (oMMU_ADDR),
    .oMMU_DATA       (oMMU_DATA),
    .iMMU_VALID      (iMMU_VALID),
    .iMMU_DATA       (iMMU_DATA),
    .iMMU_PAGEFAULT  (iMMU_PAGEFAULT),
    .oIF_VALID       (oIF_VALID),
    .oLS_VALID       (oLS_VALID),
    .oRESP_DATA      (oRESP_DATA),
    .oRESP_PAGEFAULT (oRESP_PAGEFAULT)
  );

  // Clock / reset
  initial iCLOCK = 1'b0;
  always #5 iCLOCK = ~iCLOCK;

  task automatic tick();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic idle_inputs();
    iIF_REQ        = 1'b0;
    iIF_ADDR       = '0;
    iLS_REQ        = 1'b0;
    iLS_ORDER      = '0;
    iLS_MASK       = '0;
    iLS_RW         = 1'b0;
    iLS_ADDR       = '0;
    iLS_DATA       = '0;
    iMMU_LOCK      = 1'b0;
    iMMU_VALID     = 1'b0;
    iMMU_DATA      = '0;
    iMMU_PAGEFAULT = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    iRESET_SYNC = 1'b1;
    tick();
    iRESET_SYNC = 1'b0;
  endtask

  task automatic test_reset();
    iRESET_SYNC = 1'b1;
    idle_inputs();
    tick();
    tick();
    iRESET_SYNC = 1'b0;
    #1;
    n_checks++;
    if ({oMMU_REQ, oMMU_ORDER, oMMU_MASK, oMMU_RW} !== 8'h0) begin
      n_fail++; $display("FAIL reset_req_fields: got %h want 0", {oMMU_REQ, oMMU_ORDER, oMMU_MASK, oMMU_RW});
    end
    n_checks++;
    if ({oMMU_ADDR, oMMU_DATA} !== 64'h0) begin
      n_fail++; $display("FAIL reset_payload: got %h want 0", {oMMU_ADDR, oMMU_DATA});
    end
    n_checks++;
    if ({oIF_VALID, oLS_VALID, oRESP_PAGEFAULT, oIF_LOCK, oLS_LOCK} !== 5'h0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 00000", {oIF_VALID, oLS_VALID, oRESP_PAGEFAULT, oIF_LOCK, oLS_LOCK});
    end
    n_checks++;
    if (oRESP_DATA !== 64'h0) begin
      n_fail++; $display("FAIL reset_resp_data: got %h want 0", oRESP_DATA);
    end
  endtask

  task automatic test_if_read();
    iIF_REQ  = 1'b1;
    iIF_ADDR = 32'h16;
    #1;
    n_checks++;
    if (oIF_LOCK !== 1'b0) begin n_fail++; $display("FAIL if_read_lock: got %b want 0", oIF_LOCK); end
    tick();
    iIF_REQ = 1'b0;
    n_checks++;
    if ({oMMU_REQ, oMMU_ORDER, oMMU_MASK, oMMU_RW} !== {1'b1, 2'h2, 4'hf, 1'b0}) begin
      n_fail++; $display("FAIL if_read_fields: got %h want %h", {oMMU_REQ, oMMU_ORDER, oMMU_MASK, oMMU_RW}, {1'b1, 2'h2, 4'hf, 1'b0});
    end
    n_checks++;
    if ({oMMU_ADDR, oMMU_DATA} !== {32'h16, 32'h0}) begin
      n_fail++; $display("FAIL if_read_payload: got %h want %h", {oMMU_ADDR, oMMU_DATA}, {32'h16, 32'h0});
    end
    tick();
    n_checks++;
    if (oMMU_REQ !== 1'b0) begin n_fail++; $display("FAIL if_read_req_clear: got %b want 0", oMMU_REQ); end
    iMMU_VALID = 1'b1;
    iMMU_DATA  = 64'h0000000200000002;
    tick();
    iMMU_VALID = 1'b0;
    n_checks++;
    if ({oIF_VALID, oLS_VALID, oRESP_PAGEFAULT} !== 3'b100) begin
      n_fail++; $display("FAIL if_read_cpl_flags: got %b want 100", {oIF_VALID, oLS_VALID, oRESP_PAGEFAULT});
    end
    n_checks++;
    if (oRESP_DATA !== 64'h0000000200000002) begin
      n_fail++; $display("FAIL if_read_cpl_data: got %h want 0000000200000002", oRESP_DATA);
    end
    tick();
    n_checks++;
    if (oIF_VALID !== 1'b0) begin n_fail++; $display("FAIL if_read_valid_pulse: got %b want 0", oIF_VALID); end
  endtask

  // Both requesters active for 8 cycles; a completion every cycle keeps one outstanding.
  task automatic test_both_active();
    logic        exp_ls;
    logic        cur_owner;
    logic        prev_owner;
    logic [31:0] prev_addr;
    apply_reset();
    exp_q.delete();
    prev_owner = 1'b0;
    cur_owner  = 1'b0;
    prev_addr  = '0;
    for (int k = 0; k < 8; k++) begin
      iIF_REQ    = 1'b1;
      iIF_ADDR   = 32'h200 + 32'(k);
      iLS_REQ    = 1'b1;
      iLS_ADDR   = 32'h100 + 32'(k);
      iLS_DATA   = 32'h5000 + 32'(k);
      iLS_MASK   = 4'h3;
      iLS_ORDER  = 2'h1;
      iMMU_VALID = (k > 0);
`ifdef MMU_ARB_ROUND_ROBIN_EN
      exp_ls = (k % 2 == 1);
`else
      exp_ls = 1'b1;
`endif
      #1;
      n_checks++;
      if ({oIF_LOCK, oLS_LOCK} !== {exp_ls, !exp_ls}) begin
        n_fail++; $display("FAIL both_locks[%0d]: got %b want %b", k, {oIF_LOCK, oLS_LOCK}, {exp_ls, !exp_ls});
      end
      if (k >= 1) begin
        n_checks++;
        if (oMMU_ADDR !== prev_addr) begin
          n_fail++; $display("FAIL both_addr[%0d]: got %h want %h", k, oMMU_ADDR, prev_addr);
        end
      end
      if (k >= 2) begin
        n_checks++;
        if ({oIF_VALID, oLS_VALID} !== {!prev_owner, prev_owner}) begin
          n_fail++; $display("FAIL both_route[%0d]: got %b want %b", k, {oIF_VALID, oLS_VALID}, {!prev_owner, prev_owner});
        end
      end
      if (k >= 1) begin
        cur_owner  = exp_q.pop_front();
        prev_owner = cur_owner;
      end
      exp_q.push_back(exp_ls);
      prev_addr = exp_ls ? iLS_ADDR : iIF_ADDR;
      tick();
    end
    iIF_REQ    = 1'b0;
    iLS_REQ    = 1'b0;
    iMMU_VALID = 1'b1;
    cur_owner  = exp_q.pop_front();
    tick();
    iMMU_VALID = 1'b0;
    n_checks++;
    if ({oIF_VALID, oLS_VALID} !== {!cur_owner, cur_owner}) begin
      n_fail++; $display("FAIL both_drain: got %b want %b", {oIF_VALID, oLS_VALID}, {!cur_owner, cur_owner});
    end
    tick();
  endtask

  task automatic test_lock_hold();
    apply_reset();
    iLS_REQ   = 1'b1;
    iLS_RW    = 1'b1;
    iLS_ADDR  = 32'h128;
    iLS_DATA  = 32'hdeadbeef;
    iLS_MASK  = 4'hf;
    iLS_ORDER = 2'h2;
    #1;
    n_checks++;
    if (oLS_LOCK !== 1'b0) begin n_fail++; $display("FAIL hold_first_grant: got %b want 0", oLS_LOCK); end
    tick();
    iMMU_LOCK = 1'b1;
    iIF_REQ   = 1'b1;
    iIF_ADDR  = 32'h777;
    iLS_ADDR  = 32'h999;
    iLS_DATA  = 32'h12345678;
    iLS_RW    = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if ({oMMU_REQ, oMMU_RW, oMMU_ADDR, oMMU_DATA} !== {1'b1, 1'b1, 32'h128, 32'hdeadbeef}) begin
        n_fail++; $display("FAIL hold_payload[%0d]: got %b %b %h %h want 1 1 128 deadbeef", c, oMMU_REQ, oMMU_RW, oMMU_ADDR, oMMU_DATA);
      end
      n_checks++;
      if ({oIF_LOCK, oLS_LOCK} !== 2'b11) begin
        n_fail++; $display("FAIL hold_locks[%0d]: got %b want 11", c, {oIF_LOCK, oLS_LOCK});
      end
      tick();
    end
    iMMU_LOCK = 1'b0;
    iIF_REQ   = 1'b0;
    iLS_REQ   = 1'b0;
    #1;
    n_checks++;
    if ({oMMU_REQ, oMMU_ADDR} !== {1'b1, 32'h128}) begin
      n_fail++; $display("FAIL hold_release: got %b %h want 1 128", oMMU_REQ, oMMU_ADDR);
    end
    tick();
    n_checks++;
    if (oMMU_REQ !== 1'b0) begin n_fail++; $display("FAIL hold_transferred: got %b want 0", oMMU_REQ); end
    iMMU_VALID = 1'b1;
    tick();
    iMMU_VALID = 1'b0;
    n_checks++;
    if ({oIF_VALID, oLS_VALID} !== 2'b01) begin
      n_fail++; $display("FAIL hold_cpl: got %b want 01", {oIF_VALID, oLS_VALID});
    end
    tick();
  endtask

  task automatic test_full();
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      iIF_REQ  = 1'b1;
      iIF_ADDR = 32'h40 + 32'(4 * k);
      #1;
      n_checks++;
      if (oIF_LOCK !== 1'b0) begin n_fail++; $display("FAIL full_fill[%0d]: got %b want 0", k, oIF_LOCK); end
      tick();
    end
    iIF_ADDR = 32'h50;
    #1;
    n_checks++;
    if (oIF_LOCK !== 1'b1) begin n_fail++; $display("FAIL full_blocked: got %b want 1", oIF_LOCK); end
    iMMU_VALID = 1'b1;
    #1;
    n_checks++;
    if (oIF_LOCK !== 1'b1) begin n_fail++; $display("FAIL full_blocked_with_pop: got %b want 1", oIF_LOCK); end
    tick();
    iMMU_VALID = 1'b0;
    #1;
    n_checks++;
    if (oIF_LOCK !== 1'b0) begin n_fail++; $display("FAIL full_next_grant: got %b want 0", oIF_LOCK); end
    n_checks++;
    if (oIF_VALID !== 1'b1) begin n_fail++; $display("FAIL full_cpl0: got %b want 1", oIF_VALID); end
    tick();
    iIF_REQ = 1'b0;
    n_checks++;
    if (oMMU_ADDR !== 32'h50) begin n_fail++; $display("FAIL full_fifth_addr: got %h want 50", oMMU_ADDR); end
    iMMU_VALID = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (oIF_VALID !== 1'b1) begin n_fail++; $display("FAIL full_drain[%0d]: got %b want 1", k, oIF_VALID); end
    end
    iMMU_VALID = 1'b0;
    tick();
    n_checks++;
    if (oIF_VALID !== 1'b0) begin n_fail++; $display("FAIL full_empty_drop: got %b want 0", oIF_VALID); end
  endtask

  task automatic test_order_pagefault();
    apply_reset();
    iIF_REQ = 1'b1; iIF_ADDR = 32'h60;
    tick();
    iIF_REQ = 1'b0; iLS_REQ = 1'b1; iLS_ADDR = 32'h64;
    tick();
    iLS_REQ = 1'b0; iIF_REQ = 1'b1; iIF_ADDR = 32'h68;
    tick();
    iIF_REQ    = 1'b0;
    iMMU_VALID = 1'b1;
    iMMU_DATA  = 64'h1111;
    tick();
    iMMU_VALID     = 1'b0;
    iMMU_PAGEFAULT = 1'b1;
    iMMU_DATA      = 64'h2222;
    n_checks++;
    if ({oIF_VALID, oLS_VALID, oRESP_PAGEFAULT, oRESP_DATA} !== {3'b100, 64'h1111}) begin
      n_fail++; $display("FAIL order_cpl0: got %b %h want 100 1111", {oIF_VALID, oLS_VALID, oRESP_PAGEFAULT}, oRESP_DATA);
    end
    tick();
    iMMU_PAGEFAULT = 1'b0;
    iMMU_VALID     = 1'b1;
    iMMU_DATA      = 64'h3333;
    n_checks++;
    if ({oIF_VALID, oLS_VALID, oRESP_PAGEFAULT} !== 3'b011) begin
      n_fail++; $display("FAIL order_cpl1_fault: got %b want 011", {oIF_VALID, oLS_VALID, oRESP_PAGEFAULT});
    end
    tick();
    iMMU_VALID = 1'b0;
    n_checks++;
    if ({oIF_VALID, oLS_VALID, oRESP_PAGEFAULT, oRESP_DATA} !== {3'b100, 64'h3333}) begin
      n_fail++; $display("FAIL order_cpl2: got %b %h want 100 3333", {oIF_VALID, oLS_VALID, oRESP_PAGEFAULT}, oRESP_DATA);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    iIF_REQ = 1'b1; iIF_ADDR = 32'h70;
    tick();
    iIF_ADDR = 32'h74;
    tick();
    iIF_REQ = 1'b0; iLS_REQ = 1'b1; iLS_ADDR = 32'h78; iLS_DATA = 32'hcafe;
    tick();
    iLS_REQ     = 1'b0;
    iRESET_SYNC = 1'b1;
    tick();
    iRESET_SYNC = 1'b0;
    n_checks++;
    if ({oMMU_REQ, oMMU_ADDR, oMMU_DATA, oMMU_MASK, oMMU_ORDER, oMMU_RW} !== 76'h0) begin
      n_fail++; $display("FAIL rstmid_req: got %b %h %h want 0", oMMU_REQ, oMMU_ADDR, oMMU_DATA);
    end
    n_checks++;
    if ({oIF_VALID, oLS_VALID, oRESP_PAGEFAULT, oRESP_DATA} !== 67'h0) begin
      n_fail++; $display("FAIL rstmid_resp: got %b %h want 0", {oIF_VALID, oLS_VALID, oRESP_PAGEFAULT}, oRESP_DATA);
    end
    iMMU_VALID = 1'b1;
    iMMU_DATA  = 64'hbad;
    tick();
    iMMU_VALID = 1'b0;
    n_checks++;
    if ({oIF_VALID, oLS_VALID, oRESP_DATA} !== 66'h0) begin
      n_fail++; $display("FAIL rstmid_stale_cpl: got %b %h want 0", {oIF_VALID, oLS_VALID}, oRESP_DATA);
    end
    iLS_REQ = 1'b1; iLS_ADDR = 32'h80;
    tick();
    iLS_REQ = 1'b0;
    n_checks++;
    if ({oMMU_REQ, oMMU_ADDR} !== {1'b1, 32'h80}) begin
      n_fail++; $display("FAIL rstmid_recover_req: got %b %h want 1 80", oMMU_REQ, oMMU_ADDR);
    end
    iMMU_VALID = 1'b1;
    iMMU_DATA  = 64'h4444;
    tick();
    iMMU_VALID = 1'b0;
    n_checks++;
    if ({oIF_VALID, oLS_VALID, oRESP_DATA} !== {2'b01, 64'h4444}) begin
      n_fail++; $display("FAIL rstmid_recover_cpl: got %b %h want 01 4444", {oIF_VALID, oLS_VALID}, oRESP_DATA);
    end
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_if_read();
    test_both_active();
    test_lock_hold();
    test_full();
    test_order_pagefault();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmu_access_arbiter.md
# mmu_access_arbiter

Shares the single logic-request port of `mmu` between the instruction-fetch unit (IF) and the load/store unit (LS). It grants one request per cycle and registers it toward the MMU. It also tracks outstanding requests in an in-order ID FIFO, so each MMU completion (data or page fault) is routed back to its owner. It sits between the core front-ends and `mmu`; the MMU-mode inputs (`iLOGIC_MOD`, `iLOGIC_MMUPS`, `iLOGIC_PDT`) bypass this block.

## Interface
- P_DEPTH, 4, maximum outstanding requests, counting the one held in the output register (power of two, 2..16)
- iCLOCK  in  1  clock, rising edge
- iRESET_SYNC  in  1  synchronous active-high reset
- iIF_REQ  in  1  fetch request; read-only, word order, mask 4'hf
- oIF_LOCK  out  1  fetch request not accepted this cycle
- iIF_ADDR  in  32  fetch logic address
- iLS_REQ  in  1  load/store request
- oLS_LOCK  out  1  LS request not accepted this cycle
- iLS_ORDER  in  2  LS access order
- iLS_MASK  in  4  LS byte mask
- iLS_RW  in  1  0=read 1=write
- iLS_ADDR  in  32  LS logic address
- iLS_DATA  in  32  LS store data
- oMMU_REQ  out  1  request to `mmu` iLOGIC_REQ
- iMMU_LOCK  in  1  `mmu` oLOGIC_LOCK
- oMMU_ORDER  out  2  request order
- oMMU_MASK  out  4  request mask
- oMMU_RW  out  1  request direction
- oMMU_ADDR  out  32  request address
- oMMU_DATA  out  32  request store data
- iMMU_VALID  in  1  completion pulse (read data or write ack)
- iMMU_DATA  in  64  completion data
- iMMU_PAGEFAULT  in  1  completion by page fault; mutually exclusive with iMMU_VALID
- oIF_VALID  out  1  completion for IF
- oLS_VALID  out  1  completion for LS
- oRESP_DATA  out  64  completion data, shared by both requesters
- oRESP_PAGEFAULT  out  1  completion is a page fault; qualifies oIF_VALID and oLS_VALID

## Operation
- Requester transfer: iXX_REQ=1 and oXX_LOCK=0 in the same cycle. MMU transfer: oMMU_REQ=1 and iMMU_LOCK=0.
- out_free = !oMMU_REQ or !iMMU_LOCK.
- can_grant = out_free and count < P_DEPTH. The FIFO count is checked before any same-cycle pop, so a full FIFO blocks the grant even when a completion pops in that cycle.
- Arbitration when both requesters are active: see Configuration. A lone requester is granted whenever can_grant=1.
- oXX_LOCK = !can_grant, or the other requester wins this cycle. This signal is combinational.
- On grant:
  - The payload is loaded into the output register and oMMU_REQ is set.
  - The owner ID (0=IF, 1=LS) is pushed into the FIFO.
  - For IF: ORDER=2'h2, MASK=4'hf, RW=0, DATA=0.
- With no grant and out_free, oMMU_REQ clears. While iMMU_LOCK=1 the payload is held stable.
- The MMU returns exactly one completion (iMMU_VALID or iMMU_PAGEFAULT) per accepted request, in order.
- On completion:
  - The FIFO head is popped.
  - The pulse goes to the owner's valid output.
  - iMMU_DATA goes to oRESP_DATA; the pagefault flag goes to oRESP_PAGEFAULT.
- A completion arriving with the FIFO empty is a protocol error. It is dropped; no valid is emitted.
- A push and a pop in the same cycle leave count unchanged.

## Timing
- Reset values: all outputs 0. FIFO empty. Round-robin pointer points to IF.
- iRESET_SYNC mid-operation clears the FIFO and the output register on the next edge. Completions for in-flight requests that arrive after reset are dropped.
- Request latency: grant at cycle N gives oMMU_REQ=1 at N+1.
- Completion routing: registered; iMMU_VALID at cycle M gives oXX_VALID at M+1.
- Throughput: one request per cycle while iMMU_LOCK=0 and count < P_DEPTH.

## Configuration
- MMU_ARB_ROUND_ROBIN_EN defined:
  - When both requesters are active, the one not granted last wins.
  - The pointer updates only on a grant.
- Undefined: fixed priority, LS over IF.

## Structure
- Shared package `mmu_arb_pkg`:
  - owner ID localparams (PL_OWNER_IF=1'b0, PL_OWNER_LS=1'b1)
  - IF fixed order/mask constants
  - completion-type encoding
- Sub-module `mmu_arb_id_fifo`: synchronous FIFO, width 1, depth P_DEPTH, with count output.

## Test plan
- Single IF read of 32'h16 with iMMU_LOCK=0:
  - oMMU_REQ=1 one cycle later with ADDR=32'h16, RW=0, MASK=4'hf.
  - Completion data 64'h0000000200000002 appears on oRESP_DATA with oIF_VALID one cycle after iMMU_VALID.
- IF and LS request together for 8 cycles:
  - With the macro: grants alternate IF/LS.
  - Without the macro: LS always wins and oIF_LOCK=1 throughout.
- iMMU_LOCK held high 5 cycles with a pending LS write of 32'hdeadbeef to 32'h128: payload stays stable, both LOCKs stay high, and the transfer occurs on the cycle the lock drops.
- P_DEPTH=4, four accepted reads with no completions: fifth request locked. A completion in the same cycle as the fifth request still locks it; the fifth is granted the next cycle.
- Completion order IF, LS, IF with the second completion being iMMU_PAGEFAULT=1: oLS_VALID=1 and oRESP_PAGEFAULT=1 on the second completion only.
- Assert iRESET_SYNC with 3 requests outstanding: next cycle all outputs are 0, and a later iMMU_VALID produces no valid output.
